// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// The 640x480@60 timing constants, the default sync polarity and the colour-bar table.
package vga_timing_pkg;

    // Coordinate width used for both axes
    localparam int COORD_W = 11;

    // Horizontal timing, in pixels
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync asserted level: 0 means active-low
    localparam logic VGA_SYNC_POL = 1'b0;

    // The eight test bars, left to right
    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    // Per-channel on/off mask of a bar, ordered {red, green, blue}
    function automatic logic [2:0] bar_rgb(input bar_e bar);
        logic [2:0] rgb;
        case (bar)
            BAR_WHITE:   rgb = 3'b111;
            BAR_YELLOW:  rgb = 3'b110;
            BAR_CYAN:    rgb = 3'b011;
            BAR_GREEN:   rgb = 3'b010;
            BAR_MAGENTA: rgb = 3'b101;
            BAR_RED:     rgb = 3'b100;
            BAR_BLUE:    rgb = 3'b001;
            default:     rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered sync decode.
// Active and sync are decoded from the value the counter is about to take, so the
// registered sync (and the parent's registered video_on) line up with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int   ACTIVE   = VGA_H_ACTIVE,
    parameter int   FP       = VGA_H_FP,
    parameter int   SYNC     = VGA_H_SYNC,
    parameter int   BP       = VGA_H_BP,
    parameter logic SYNC_POL = VGA_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               advance,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               active_next,
    output logic               sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_END    = COORD_W'(ACTIVE);
    localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(ACTIVE + FP);
    localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE + FP + SYNC);

    logic [COORD_W-1:0] count_reg;
    logic [COORD_W-1:0] count_next;
    logic               sync_reg;
    logic               sync_next;

    // Next position and the decode of that next position
    always_comb begin
        wrap       = advance && (count_reg == LAST);
        count_next = count_reg;
        if (advance) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
        active_next = (count_next < ACT_END);
        sync_next   = ((count_next >= SYNC_START) && (count_next < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Position and sync registers; reset parks on the last position so the first advance gives 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= LAST;
            sync_reg  <= ~SYNC_POL;
        end else begin
            count_reg <= count_next;
            sync_reg  <= sync_next;
        end
    end

    assign count = count_reg;
    assign sync  = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, registered sync,
// video_on and line/frame markers, plus sync copies delayed by SYNC_DLY clocks.
// Optional feature: define VGA_PATTERN_EN to add the rgb_pattern colour-bar output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV    = 4,
    parameter int   H_ACTIVE   = VGA_H_ACTIVE,
    parameter int   H_FP       = VGA_H_FP,
    parameter int   H_SYNC     = VGA_H_SYNC,
    parameter int   H_BP       = VGA_H_BP,
    parameter int   V_ACTIVE   = VGA_V_ACTIVE,
    parameter int   V_FP       = VGA_V_FP,
    parameter int   V_SYNC     = VGA_V_SYNC,
    parameter int   V_BP       = VGA_V_BP,
    parameter logic SYNC_POL   = VGA_SYNC_POL,
    parameter int   SYNC_DLY   = 1,
    parameter int   DATA_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               pix_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               hsync_dly,
    output logic               vsync_dly,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_PATTERN_EN
    ,
    output logic [DATA_WIDTH-1:0] rgb_pattern
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Pattern channels are split evenly three ways
    if (DATA_WIDTH % 3 != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of 3");
    end

    logic [DIV_W-1:0] div_reg;
    logic             advance;
    logic             h_wrap, v_wrap;
    logic             h_act_next, v_act_next;
    logic             h_sync, v_sync;
    logic             pix_tick_reg, line_start_reg, frame_start_reg, video_on_reg;

    assign advance = en && (div_reg == DIV_LAST);

    // Pixel-rate divider; holds its count while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg <= '0;
        end else if (en) begin
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (advance),
        .count       (pixel_x),
        .wrap        (h_wrap),
        .active_next (h_act_next),
        .sync        (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (h_wrap),
        .count       (pixel_y),
        .wrap        (v_wrap),
        .active_next (v_act_next),
        .sync        (v_sync)
    );

    // Tick/marker pulses and video_on, registered so they land with the new coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_tick_reg    <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            video_on_reg    <= 1'b0;
        end else begin
            pix_tick_reg    <= advance;
            line_start_reg  <= h_wrap;
            frame_start_reg <= v_wrap;
            video_on_reg    <= h_act_next && v_act_next;
        end
    end

    assign pix_tick    = pix_tick_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign video_on    = video_on_reg;
    assign hsync       = h_sync;
    assign vsync       = v_sync;

    // Delayed sync copies for the downstream RGB register; runs every clk regardless of en
    if (SYNC_DLY == 0) begin : g_no_dly
        assign hsync_dly = h_sync;
        assign vsync_dly = v_sync;
    end else begin : g_dly
        logic [SYNC_DLY-1:0] hs_pipe_reg;
        logic [SYNC_DLY-1:0] vs_pipe_reg;

        // Shift register, stage 0 takes the live sync
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hs_pipe_reg <= {SYNC_DLY{~SYNC_POL}};
                vs_pipe_reg <= {SYNC_DLY{~SYNC_POL}};
            end else begin
                hs_pipe_reg[0] <= h_sync;
                vs_pipe_reg[0] <= v_sync;
                for (int i = 1; i < SYNC_DLY; i++) begin
                    hs_pipe_reg[i] <= hs_pipe_reg[i-1];
                    vs_pipe_reg[i] <= vs_pipe_reg[i-1];
                end
            end
        end

        assign hsync_dly = hs_pipe_reg[SYNC_DLY-1];
        assign vsync_dly = vs_pipe_reg[SYNC_DLY-1];
    end

`ifdef VGA_PATTERN_EN
    localparam int CH_W  = DATA_WIDTH / 3;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic [COORD_W-1:0]    x_next;
    logic [COORD_W-1:0]    bar_num;
    logic [2:0]            bar_bits;
    logic [DATA_WIDTH-1:0] bar_colour;
    logic [DATA_WIDTH-1:0] rgb_reg;

    // Bar selection from the x position about to be shown
    always_comb begin
        x_next   = h_wrap ? '0 : pixel_x + 1'b1;
        bar_num  = x_next / COORD_W'(BAR_W);
        bar_bits = (bar_num > COORD_W'(7)) ? bar_rgb(BAR_BLACK) : bar_rgb(bar_e'(bar_num[2:0]));
    end

    // Each channel is a full-width replica of its on/off bit; gi=2 is red (MSBs)
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign bar_colour[gi*CH_W +: CH_W] = {CH_W{bar_bits[gi]}};
    end

    // Pattern register, blanked outside the active area, updated with the coordinates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg <= '0;
        end else if (advance) begin
            rgb_reg <= (h_act_next && v_act_next) ? bar_colour : '0;
        end
    end

    assign rgb_pattern = rgb_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen using a reduced raster (24x13) so whole frames fit in a short run.
// Reference model: pixel position is derived arithmetically from the number of ticks since reset.
module tb_vga_timing_gen;

    localparam int CD = 4;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int SD = 2;
    localparam bit SP = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        pix_tick, video_on, hsync, vsync, hsync_dly, vsync_dly, line_start, frame_start;
    logic [10:0] pixel_x, pixel_y;
`ifdef VGA_PATTERN_EN
    logic [11:0] rgb_pattern;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (CD), .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (SP), .SYNC_DLY (SD), .DATA_WIDTH (12)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en (en),
        .pix_tick (pix_tick), .pixel_x (pixel_x), .pixel_y (pixel_y),
        .video_on (video_on), .hsync (hsync), .vsync (vsync),
        .hsync_dly (hsync_dly), .vsync_dly (vsync_dly),
        .line_start (line_start), .frame_start (frame_start)
`ifdef VGA_PATTERN_EN
        , .rgb_pattern (rgb_pattern)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_ticks = 0;
    int m_div = 0;
    bit m_adv = 1'b0;
    bit hs_hist [4];
    bit vs_hist [4];

    function automatic int f_x(input int t);
        if (t == 0) return HT - 1;
        return ((t - 1) % (HT * VT)) % HT;
    endfunction

    function automatic int f_y(input int t);
        if (t == 0) return VT - 1;
        return ((t - 1) % (HT * VT)) / HT;
    endfunction

    function automatic bit f_hs(input int t);
        int x;
        x = f_x(t);
        return (x >= HA + HF && x < HA + HF + HS) ? SP : !SP;
    endfunction

    function automatic bit f_vs(input int t);
        int y;
        y = f_y(t);
        return (y >= VA + VF && y < VA + VF + VS) ? SP : !SP;
    endfunction

    function automatic int f_rgb(input int t);
        int tbl [8];
        tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        if (t == 0 || f_x(t) >= HA || f_y(t) >= VA) return 0;
        return tbl[f_x(t) / (HA / 8)];
    endfunction

    // Model state advance: tick count, divider phase and sync history
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ticks <= 0;
            m_div   <= 0;
            m_adv   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                hs_hist[i] <= !SP;
                vs_hist[i] <= !SP;
            end
        end else begin
            hs_hist[0] <= f_hs(m_ticks);
            vs_hist[0] <= f_vs(m_ticks);
            for (int i = 1; i < 4; i++) begin
                hs_hist[i] <= hs_hist[i-1];
                vs_hist[i] <= vs_hist[i-1];
            end
            m_adv <= en && (m_div == CD - 1);
            if (en) begin
                if (m_div == CD - 1) begin
                    m_div   <= 0;
                    m_ticks <= m_ticks + 1;
                end else begin
                    m_div <= m_div + 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        int ex, ey;
        bit at_origin;
        ex = f_x(m_ticks);
        ey = f_y(m_ticks);
        at_origin = (m_ticks > 0) && ex == 0 && ey == 0;
        check("pixel_x", int'(pixel_x), ex);
        check("pixel_y", int'(pixel_y), ey);
        check("pix_tick", int'(pix_tick), int'(m_adv));
        check("video_on", int'(video_on), int'(m_ticks > 0 && ex < HA && ey < VA));
        check("hsync", int'(hsync), int'(f_hs(m_ticks)));
        check("vsync", int'(vsync), int'(f_vs(m_ticks)));
        check("hsync_dly", int'(hsync_dly), int'(hs_hist[SD-1]));
        check("vsync_dly", int'(vsync_dly), int'(vs_hist[SD-1]));
        check("line_start", int'(line_start), int'(m_adv && ex == 0));
        check("frame_start", int'(frame_start), int'(m_adv && at_origin));
`ifdef VGA_PATTERN_EN
        check("rgb_pattern", int'(rgb_pattern), f_rgb(m_ticks));
`endif
    end

    // Wait for the next pix_tick (sampled on the falling edge), bounded
    task automatic wait_tick();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (pix_tick) return;
        end
        check("tick_timeout", 1, 0);
    endtask

    // Release reset and verify the first tick lands at the origin after CD clocks
    task automatic release_and_check_first();
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (pix_tick) break;
        end
        check("first_tick_latency", n, 4);
        check("first_x", int'(pixel_x), 0);
        check("first_y", int'(pixel_y), 0);
        check("first_frame_start", int'(frame_start), 1);
        check("first_line_start", int'(line_start), 1);
        check("first_video_on", int'(video_on), 1);
        $display("release: first tick after %0d clk at (%0d,%0d)", n, pixel_x, pixel_y);
    endtask

    initial begin
        int nt, hs_low, hs_first, vs_low, von, nls;
        bit seen_frame;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x", int'(pixel_x), 23);
        check("rst_y", int'(pixel_y), 12);
        check("rst_video_on", int'(video_on), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_hsync_dly", int'(hsync_dly), 1);

        release_and_check_first();

        // One full frame measured from the origin tick
        nt = 1; hs_low = 0; hs_first = -1; vs_low = 0; von = 0; nls = 0; seen_frame = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (k > 0) begin
                wait_tick();
                if (frame_start) begin
                    seen_frame = 1'b1;
                    break;
                end
                nt++;
            end
            if (pixel_y == 0 && hsync == 1'b0) begin
                if (hs_first < 0) hs_first = int'(pixel_x);
                hs_low++;
            end
            if (vsync == 1'b0) vs_low++;
            if (video_on) von++;
            if (line_start) nls++;
`ifdef VGA_PATTERN_EN
            if (pixel_y == 0 && pixel_x == 0) check("pat_x0", int'(rgb_pattern), 12'hFFF);
            if (pixel_y == 0 && pixel_x == 2) check("pat_x2", int'(rgb_pattern), 12'hFF0);
            if (pixel_y == 1 && pixel_x == 15) check("pat_x15", int'(rgb_pattern), 12'h000);
            if (pixel_y == 1 && pixel_x == 16) check("pat_blank", int'(rgb_pattern), 0);
`endif
        end
        check("frame_seen", int'(seen_frame), 1);
        check("ticks_per_frame", nt, 312);
        check("hsync_low_ticks", hs_low, 3);
        check("hsync_first_x", hs_first, 18);
        check("vsync_low_ticks", vs_low, 48);
        check("video_on_ticks", von, 128);
        check("line_starts", nls, 13);
        $display("frame: %0d ticks, hs_low=%0d from x=%0d, vs_low=%0d", nt, hs_low, hs_first, vs_low);

        // Freeze at x=5
        for (int k = 0; k < 40; k++) begin
            wait_tick();
            if (pixel_x == 5) break;
        end
        en = 1'b0;
        nt = 0;
        repeat (50) begin
            @(negedge clk);
            if (pix_tick) nt++;
        end
        check("freeze_ticks", nt, 0);
        check("freeze_x", int'(pixel_x), 5);
        en = 1'b1;
        wait_tick();
        check("resume_x", int'(pixel_x), 6);
        $display("freeze: resumed at x=%0d", pixel_x);

        // Randomised enable
        repeat (3000) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) < 8);
        end
        en = 1'b1;

        // Asynchronous reset at (10,4)
        for (int k = 0; k < 400; k++) begin
            wait_tick();
            if (pixel_x == 10 && pixel_y == 4) break;
        end
        check("pre_reset_x", int'(pixel_x), 10);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_x", int'(pixel_x), 23);
        check("async_y", int'(pixel_y), 12);
        check("async_video_on", int'(video_on), 0);
        check("async_pix_tick", int'(pix_tick), 0);
        check("async_hsync_dly", int'(hsync_dly), 1);
        check("async_vsync", int'(vsync), 1);
        $display("async reset: outputs at (%0d,%0d)", pixel_x, pixel_y);
        repeat (3) @(negedge clk);
        release_and_check_first();

        // Randomised enable with random reset pulses
        repeat (2500) begin
            @(negedge clk);
            en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 999) == 0) begin
                #1 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
